// File: rtl/mic_frame_writer.sv
// Packs MIC_N-channel PCM sample sets into ping-pong RAM banks and posts a mailbox word + IRQ per frame.
// Define MIC_FRAME_TIMESTAMP_EN to prepend a sample-edge count header word to each bank.
module mic_frame_writer #(
  parameter int MIC_N     = 8,
  parameter int SAMPLE_W  = 16,
  parameter int FRAME_LEN = 64,
  parameter int ADDR_W    = 10,
  parameter int MBOX_ADDR = 1023
) (
  input  logic                      sys_clk,
  input  logic                      core_reset_n,
  input  logic                      enable,
  input  logic [MIC_N*SAMPLE_W-1:0] sample_data,
  input  logic                      sample_valid,
  output logic [ADDR_W-1:0]         ram_address,
  output logic                      ram_chipselect,
  output logic                      ram_write,
  output logic [31:0]               ram_writedata,
  output logic [3:0]                ram_byteenable,
  input  logic [31:0]               ram_readdata,
  output logic                      irq,
  output logic [15:0]               overrun_cnt,
  output logic [15:0]               drop_cnt
);
  localparam int SET_W = MIC_N*SAMPLE_W;
  localparam int WPS   = SET_W/32;
`ifdef MIC_FRAME_TIMESTAMP_EN
  localparam int HDR   = 1;
`else
  localparam int HDR   = 0;
`endif
  localparam int WPB   = FRAME_LEN*WPS + HDR;
  localparam int WW    = (WPS > 1) ? $clog2(WPS) : 1;
  localparam int SW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN+1) : 1;

  localparam logic [ADDR_W-1:0] A_WPB  = ADDR_W'(WPB);
  localparam logic [ADDR_W-1:0] A_WPS  = ADDR_W'(WPS);
  localparam logic [ADDR_W-1:0] A_HDR  = ADDR_W'(HDR);
  localparam logic [ADDR_W-1:0] A_MBOX = ADDR_W'(MBOX_ADDR);
  localparam logic [WW-1:0]     LAST_W = WW'(WPS-1);
  localparam logic [SW-1:0]     LAST_S = SW'(FRAME_LEN-1);

  typedef enum logic [2:0] {IDLE, WR_HDR, WR_SET, FRAME_END, MBOX_WR, POLL_RD, POLL_CHK} state_t;

  state_t                  r_state, w_nxt;
  logic [2:0]              r_sync;
  logic                    r_pending;
  logic [WPS-1:0][31:0]    r_snap;
  logic [WW-1:0]           r_word;
  logic [SW-1:0]           r_set_idx;
  logic                    r_bank;
  logic [15:0]             r_seq;
  logic                    r_mbox_busy;
  logic [15:0]             r_over, r_drop;
  logic                    w_edge, w_take, w_drop, w_set_done, w_first_hdr;
  logic [ADDR_W-1:0]       w_base;

  assign w_edge     = r_sync[1] & ~r_sync[2];
  assign w_take     = w_edge & enable & ~r_pending;
  assign w_drop     = w_edge & enable & r_pending;
  assign w_set_done = (r_state == WR_SET) && (r_word == LAST_W);
  assign w_base     = r_bank ? A_WPB : '0;

  assign ram_byteenable = 4'b1111;
  assign irq            = r_mbox_busy;
  assign overrun_cnt    = r_over;
  assign drop_cnt       = r_drop;

  // Capture side: synchronise the slow-domain valid, snapshot one set at a time.
  always_ff @(posedge sys_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      r_sync    <= '0;
      r_pending <= 1'b0;
      r_snap    <= '0;
      r_drop    <= '0;
    end else begin
      r_sync <= {r_sync[1:0], sample_valid};
      if (w_take) begin
        r_snap    <= sample_data;
        r_pending <= 1'b1;
      end else if (w_set_done) begin
        r_pending <= 1'b0;
      end
      if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
    end
  end

`ifdef MIC_FRAME_TIMESTAMP_EN
  logic [31:0] r_edge_cnt, r_ts;
  assign w_first_hdr = (r_set_idx == '0);
  // Header reports edges seen before the frame's first captured set.
  always_ff @(posedge sys_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      r_edge_cnt <= '0;
      r_ts       <= '0;
    end else begin
      if (w_edge) r_edge_cnt <= r_edge_cnt + 32'd1;
      if (w_take) r_ts       <= r_edge_cnt;
    end
  end
`else
  assign w_first_hdr = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge core_reset_n) begin
    if (!core_reset_n) r_state <= IDLE;
    else               r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (r_pending)        w_nxt = w_first_hdr ? WR_HDR : WR_SET;
        else if (r_mbox_busy) w_nxt = POLL_RD;
      end
      WR_HDR:    w_nxt = WR_SET;
      WR_SET:    if (r_word == LAST_W) w_nxt = (r_set_idx == LAST_S) ? FRAME_END : IDLE;
      FRAME_END: w_nxt = r_mbox_busy ? IDLE : MBOX_WR;
      MBOX_WR:   w_nxt = IDLE;
      POLL_RD:   w_nxt = POLL_CHK;
      POLL_CHK:  w_nxt = IDLE;
      default:   w_nxt = IDLE;
    endcase
  end

  always_comb begin
    ram_chipselect = 1'b0;
    ram_write      = 1'b0;
    ram_address    = '0;
    ram_writedata  = '0;
    case (r_state)
`ifdef MIC_FRAME_TIMESTAMP_EN
      WR_HDR: begin
        ram_chipselect = 1'b1;
        ram_write      = 1'b1;
        ram_address    = w_base;
        ram_writedata  = r_ts;
      end
`endif
      WR_SET: begin
        ram_chipselect = 1'b1;
        ram_write      = 1'b1;
        ram_address    = w_base + A_HDR + ADDR_W'(r_set_idx) * A_WPS + ADDR_W'(r_word);
        ram_writedata  = r_snap[r_word];
      end
      MBOX_WR: begin
        ram_chipselect = 1'b1;
        ram_write      = 1'b1;
        ram_address    = A_MBOX;
        ram_writedata  = {1'b1, 14'd0, r_bank, r_seq};
      end
      POLL_RD: begin
        ram_chipselect = 1'b1;
        ram_address    = A_MBOX;
      end
      default: ;
    endcase
  end

  // Frame bookkeeping; an overrun rewrites the same bank with the same seq.
  always_ff @(posedge sys_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      r_word      <= '0;
      r_set_idx   <= '0;
      r_bank      <= 1'b0;
      r_seq       <= '0;
      r_mbox_busy <= 1'b0;
      r_over      <= '0;
    end else begin
      case (r_state)
        WR_SET: begin
          if (r_word == LAST_W) begin
            r_word    <= '0;
            r_set_idx <= r_set_idx + SW'(1);
          end else begin
            r_word    <= r_word + WW'(1);
          end
        end
        FRAME_END: begin
          if (r_mbox_busy) begin
            r_set_idx <= '0;
            if (r_over != 16'hFFFF) r_over <= r_over + 16'd1;
          end
        end
        MBOX_WR: begin
          r_mbox_busy <= 1'b1;
          r_bank      <= ~r_bank;
          r_set_idx   <= '0;
          r_seq       <= r_seq + 16'd1;
        end
        POLL_CHK: if (ram_readdata == 32'd0) r_mbox_busy <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mic_frame_writer.sv
// Randomised bench for mic_frame_writer: bus RAM model, CPU mailbox clears, frame-level reference model.
module tb_mic_frame_writer;
  localparam int MIC_N = 4, SAMPLE_W = 16, FRAME_LEN = 4, ADDR_W = 6, MBOX = 63;
  localparam int SET_W = MIC_N*SAMPLE_W;
  localparam int WPS   = SET_W/32;
  localparam int WPB   = FRAME_LEN*WPS;

  logic               sys_clk, core_reset_n, enable, sample_valid;
  logic [SET_W-1:0]   sample_data;
  logic [ADDR_W-1:0]  ram_address;
  logic               ram_chipselect, ram_write;
  logic [31:0]        ram_writedata, ram_readdata;
  logic [3:0]         ram_byteenable;
  logic               irq;
  logic [15:0]        overrun_cnt, drop_cnt;

  mic_frame_writer #(.MIC_N(MIC_N), .SAMPLE_W(SAMPLE_W), .FRAME_LEN(FRAME_LEN),
                     .ADDR_W(ADDR_W), .MBOX_ADDR(MBOX)) dut (
    .sys_clk(sys_clk), .core_reset_n(core_reset_n), .enable(enable),
    .sample_data(sample_data), .sample_valid(sample_valid),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_byteenable(ram_byteenable), .ram_readdata(ram_readdata),
    .irq(irq), .overrun_cnt(overrun_cnt), .drop_cnt(drop_cnt));

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic        cpu_clr;
  always @(posedge sys_clk) begin
    if (ram_chipselect && ram_write) mem[ram_address] <= ram_writedata;
    else if (cpu_clr)                mem[MBOX]        <= 32'd0;
    if (ram_chipselect && !ram_write) ram_readdata <= mem[ram_address];
  end

  bit               mon_en;
  logic [ADDR_W-1:0] obs_a[$], exp_a[$];
  logic [31:0]       obs_d[$], exp_d[$];
  always @(negedge sys_clk)
    if (mon_en && ram_chipselect && ram_write) begin
      obs_a.push_back(ram_address);
      obs_d.push_back(ram_writedata);
    end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: frame-level bookkeeping of bank, set index, sequence and mailbox state.
  bit          m_bank, m_busy;
  int          m_set, m_over, m_drop;
  logic [15:0] m_seq;

  task automatic model_reset();
    m_bank = 0; m_busy = 0; m_set = 0; m_over = 0; m_drop = 0; m_seq = '0;
    obs_a.delete(); obs_d.delete(); exp_a.delete(); exp_d.delete();
  endtask

  task automatic accept(input logic [SET_W-1:0] d);
    for (int w = 0; w < WPS; w++) begin
      exp_a.push_back(ADDR_W'(m_bank*WPB + m_set*WPS + w));
      exp_d.push_back(d[w*32 +: 32]);
    end
    m_set++;
    if (m_set == FRAME_LEN) begin
      m_set = 0;
      if (m_busy) m_over++;
      else begin
        exp_a.push_back(ADDR_W'(MBOX));
        exp_d.push_back({1'b1, 14'd0, m_bank, m_seq});
        m_busy = 1; m_bank = ~m_bank; m_seq++;
      end
    end
  endtask

  task automatic flush(input string tag);
    chk({tag, "_nwr"}, 64'(obs_a.size()), 64'(exp_a.size()));
    while (obs_a.size() > 0 && exp_a.size() > 0) begin
      chk({tag, "_addr"}, 64'(obs_a.pop_front()), 64'(exp_a.pop_front()));
      chk({tag, "_data"}, 64'(obs_d.pop_front()), 64'(exp_d.pop_front()));
    end
    obs_a.delete(); obs_d.delete(); exp_a.delete(); exp_d.delete();
  endtask

  task automatic send(input logic [SET_W-1:0] d, input bit en);
    @(negedge sys_clk);
    sample_data = d; enable = en; sample_valid = 1'b1;
    repeat (3) @(negedge sys_clk);
    sample_valid = 1'b0;
    repeat (14) @(negedge sys_clk);
    if (en) accept(d);
  endtask

  task automatic cpu_clear();
    @(negedge sys_clk); cpu_clr = 1'b1;
    @(negedge sys_clk); cpu_clr = 1'b0;
    repeat (10) @(negedge sys_clk);
    m_busy = 0;
  endtask

  function automatic logic [SET_W-1:0] rnd_set();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [SET_W-1:0] d;
    bit found;
    core_reset_n = 1'b1; enable = 1'b0; sample_valid = 1'b0; sample_data = '0;
    cpu_clr = 1'b0; mon_en = 0;
    model_reset();
    #1 core_reset_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_cs", 64'(ram_chipselect), 64'd0);
    chk("rst_wr", 64'(ram_write), 64'd0);
    chk("rst_addr", 64'(ram_address), 64'd0);
    chk("rst_wdata", 64'(ram_writedata), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_over", 64'(overrun_cnt), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    core_reset_n = 1'b1;
    mon_en = 1;

    // Frame A: directed channel pattern
    for (int n = 1; n <= FRAME_LEN; n++) begin
      d = {16'h0D00 + 16'(n), 16'h0C00 + 16'(n), 16'h0B00 + 16'(n), 16'h0A00 + 16'(n)};
      send(d, 1'b1);
    end
    flush("frmA");
    chk("frmA_w0", 64'(mem[0]), 64'h0B01_0A01);
    chk("frmA_mbox", 64'(mem[MBOX]), 64'h8000_0000);
    chk("frmA_irq", 64'(irq), 64'd1);
    cpu_clear();
    chk("clrA_irq", 64'(irq), 64'(m_busy));

    // Frame B: random data into bank 1
    for (int n = 0; n < FRAME_LEN; n++) send(rnd_set(), 1'b1);
    flush("frmB");
    chk("frmB_mbox", 64'(mem[MBOX]), 64'h8001_0001);
    chk("frmB_irq", 64'(irq), 64'(m_busy));

    // Frames C, D with the mailbox left pending
    for (int n = 0; n < 2*FRAME_LEN; n++) send(rnd_set(), 1'b1);
    flush("frmCD");
    chk("ovr_cnt", 64'(overrun_cnt), 64'(m_over));
    chk("ovr_irq", 64'(irq), 64'(m_busy));

    // Random enable gaps across frame boundaries
    cpu_clear();
    for (int n = 0; n < 10; n++) send(rnd_set(), $urandom_range(0, 3) != 0);
    flush("mix");
    chk("mix_irq", 64'(irq), 64'(m_busy));
    chk("mix_over", 64'(overrun_cnt), 64'(m_over));

    // Two edges two cycles apart: the second is dropped
    d = rnd_set();
    @(negedge sys_clk);
    sample_data = d; enable = 1'b1; sample_valid = 1'b1;
    @(negedge sys_clk) sample_valid = 1'b0;
    @(negedge sys_clk) sample_valid = 1'b1;
    repeat (3) @(negedge sys_clk);
    sample_valid = 1'b0;
    repeat (14) @(negedge sys_clk);
    accept(d);
    m_drop++;
    flush("drop");
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));

    // Reset in the middle of a set write
    mon_en = 0;
    @(negedge sys_clk);
    sample_data = rnd_set(); sample_valid = 1'b1;
    repeat (3) @(negedge sys_clk);
    sample_valid = 1'b0;
    found = 0;
    for (int t = 0; t < 30 && !found; t++) begin
      @(negedge sys_clk);
      if (ram_chipselect && ram_write) found = 1;
    end
    chk("rst_mid_seen", 64'(found), 64'd1);
    #1 core_reset_n = 1'b0;
    #1;
    chk("rstm_cs", 64'(ram_chipselect), 64'd0);
    chk("rstm_wr", 64'(ram_write), 64'd0);
    chk("rstm_addr", 64'(ram_address), 64'd0);
    chk("rstm_wdata", 64'(ram_writedata), 64'd0);
    chk("rstm_irq", 64'(irq), 64'd0);
    chk("rstm_over", 64'(overrun_cnt), 64'd0);
    chk("rstm_drop", 64'(drop_cnt), 64'd0);
    repeat (3) @(negedge sys_clk);
    core_reset_n = 1'b1;
    model_reset();
    mon_en = 1;
    for (int n = 0; n < FRAME_LEN + 1; n++) send(rnd_set(), 1'b1);
    flush("postrst");
    chk("postrst_irq", 64'(irq), 64'(m_busy));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
